// File: rtl/spi_ctrl_pkg.sv
// Purpose: shared types and constants for the SPI transaction arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package spi_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESPOND,
        ST_GAP
    } state_t;

    localparam int DEF_NUM_REQ        = 2;
    localparam int DEF_CS_GAP_CYCLES  = 4;
    localparam int DEF_TIMEOUT_CYCLES = 4096;

    // The engine shifts at most one 32-bit word per transaction.
    localparam logic [7:0] MAX_LEN = 8'd32;

    function automatic logic [7:0] clamp_len(input logic [7:0] len);
        return (len > MAX_LEN) ? MAX_LEN : len;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Purpose: round-robin pick of one requester, searching upward from ptr with wrap.
// Latency: purely combinational.
// Backpressure: none; caller qualifies req and advances ptr on acceptance.
//
// Ports: req (request vector), ptr (highest-priority index),
//        grant (one-hot winner), idx (winner index), found (any winner).
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          found
);

    always_comb begin
        int          k;
        logic [IW-1:0] kk;
        k     = 0;
        kk    = '0;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            k = int'(ptr) + i;
            if (k >= N) k = k - N;
            kk = IW'(k);
            if (!found && req[kk]) begin
                found     = 1'b1;
                grant[kk] = 1'b1;
                idx       = kk;
            end
        end
    end

endmodule

// File: rtl/spi_transaction_arbiter.sv
// Purpose: shares one SPI engine among NUM_REQ requesters, one transaction at a time.
// Latency: accept at T -> eng_start at T+1; response one cycle after eng_done or timeout.
// Backpressure: response held until owner's rsp_ready; no grants while busy or in CS gap.
//
// Ports: spi_clk_0/reset; req_valid/req_ready/req_length/req_data/req_rw_mask (requests);
//        rsp_valid/rsp_ready/rsp_read_data/rsp_timeout (responses); eng_* (engine side);
//        busy (not IDLE), grant_id (current owner).
module spi_transaction_arbiter
    import spi_ctrl_pkg::*;
#(
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int CS_GAP_CYCLES  = DEF_CS_GAP_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    localparam int IDW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                    spi_clk_0,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [8*NUM_REQ-1:0]    req_length,
    input  logic [32*NUM_REQ-1:0]   req_data,
    input  logic [32*NUM_REQ-1:0]   req_rw_mask,
    output logic [NUM_REQ-1:0]      rsp_valid,
    input  logic [NUM_REQ-1:0]      rsp_ready,
    output logic [31:0]             rsp_read_data,
    output logic                    rsp_timeout,
    output logic                    eng_start,
    output logic [7:0]              eng_length,
    output logic [31:0]             eng_data,
    output logic [31:0]             eng_rw_mask,
    input  logic                    eng_done,
    input  logic [31:0]             eng_read_data,
    output logic                    busy,
    output logic [IDW-1:0]          grant_id
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GW = (CS_GAP_CYCLES > 0) ? $clog2(CS_GAP_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((CS_GAP_CYCLES > 0) ? CS_GAP_CYCLES - 1 : 0);
    localparam state_t AFTER_RSP = (CS_GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;

    state_t             state, state_nxt;
    logic [IDW-1:0]     rr_ptr;
    logic [TW-1:0]      tmo_cnt;
    logic [GW-1:0]      gap_cnt;

    logic [NUM_REQ-1:0] arb_req, arb_grant;
    logic [IDW-1:0]     arb_idx;
    logic               arb_found;
    logic               take;
    logic [7:0]         sel_len;
    logic [31:0]        sel_data, sel_mask;

    // Only offer requests while idle and out of reset, so a grant can never
    // fire in the same cycle the block is being cleared.
    assign arb_req = (state == ST_IDLE && !reset) ? req_valid : '0;

    rr_arbiter #(.N(NUM_REQ), .IW(IDW)) u_rr (
        .req   (arb_req),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .found (arb_found)
    );

    always_comb begin
        sel_len  = '0;
        sel_data = '0;
        sel_mask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_grant[i]) begin
                sel_len  = clamp_len(req_length[8*i +: 8]);
                sel_data = req_data[32*i +: 32];
                sel_mask = req_rw_mask[32*i +: 32];
            end
        end
    end

    assign busy = (state != ST_IDLE);

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        rsp_valid = '0;
        eng_start = 1'b0;
        take      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (arb_found) begin
                    req_ready = arb_grant;
                    take      = 1'b1;
                    // Zero-length transfers never touch the engine.
                    state_nxt = (sel_len == 8'd0) ? ST_RESPOND : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                eng_start = !reset;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                // Completion is checked first so it wins over a coincident timeout.
                if (eng_done || tmo_cnt == TMO_LAST) state_nxt = ST_RESPOND;
            end
            ST_RESPOND: begin
                rsp_valid[grant_id] = !reset;
                if (rsp_ready[grant_id]) state_nxt = AFTER_RSP;
            end
            ST_GAP: begin
                if (gap_cnt == GAP_LAST) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge spi_clk_0) begin
        if (reset) begin
            state         <= ST_IDLE;
            rr_ptr        <= '0;
            tmo_cnt       <= '0;
            gap_cnt       <= '0;
            grant_id      <= '0;
            eng_length    <= '0;
            eng_data      <= '0;
            eng_rw_mask   <= '0;
            rsp_read_data <= '0;
            rsp_timeout   <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (take) begin
                        grant_id      <= arb_idx;
                        eng_length    <= sel_len;
                        eng_data      <= sel_data;
                        eng_rw_mask   <= sel_mask;
                        rr_ptr        <= (arb_idx == IDW'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
                        tmo_cnt       <= '0;
                        gap_cnt       <= '0;
                        rsp_read_data <= '0;
                        rsp_timeout   <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (eng_done) begin
                        rsp_read_data <= eng_read_data;
                        rsp_timeout   <= 1'b0;
                    end else if (tmo_cnt == TMO_LAST) begin
                        rsp_read_data <= '0;
                        rsp_timeout   <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ST_GAP: gap_cnt <= gap_cnt + 1'b1;
                default: ;
            endcase
        end
    end

endmodule
